// File: rtl/wu_fetch_cntl.sv
//------------------------------------------------------------------------------
// Module      : wu_fetch_cntl
// Description : WU instruction-memory fetch sequencer. Optional multi-pass
//               looping is enabled by defining WUF_LOOP_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wu_fetch_cntl #(
    parameter int WUF_ADDR_WIDTH   = 12,
    parameter int WUF_MEM_DEPTH    = 4096,
    parameter int WUF_COUNT_WIDTH  = 16,
    parameter int WUF_DRAIN_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic                       mcntl__wuf__start,
    input  logic [WUF_ADDR_WIDTH-1:0]  mcntl__wuf__start_addr,
    input  logic [WUF_COUNT_WIDTH-1:0] mcntl__wuf__num_words,
    input  logic                       mcntl__wuf__abort,
`ifdef WUF_LOOP_EN
    input  logic [7:0]                 mcntl__wuf__loop_count,
`endif
    output logic                       wuf__mcntl__busy,
    output logic                       wuf__mcntl__done,
    output logic [WUF_COUNT_WIDTH-1:0] wuf__mcntl__fetch_count,
    output logic [WUF_ADDR_WIDTH-1:0]  wuf__wum__addr,
    output logic                       wuf__wum__read,
    input  logic                       wum__wuf__stall
);

    localparam int DRAIN_W = (WUF_DRAIN_CYCLES < 2) ? 1 : $clog2(WUF_DRAIN_CYCLES);

    localparam logic [DRAIN_W-1:0]         C_DRAIN_LOAD = DRAIN_W'(WUF_DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0]         C_DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [WUF_ADDR_WIDTH-1:0]  C_ADDR_LAST  = WUF_ADDR_WIDTH'(WUF_MEM_DEPTH - 1);
    localparam logic [WUF_ADDR_WIDTH-1:0]  C_ADDR_ONE   = WUF_ADDR_WIDTH'(1);
    localparam logic [WUF_COUNT_WIDTH-1:0] C_CNT_ONE    = WUF_COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                       state_q;
    logic                         read_q;
    logic [WUF_ADDR_WIDTH-1:0]    addr_q;
    logic                         busy_q;
    logic                         done_q;
    logic [WUF_COUNT_WIDTH-1:0]   fetch_count_q;
    logic [WUF_COUNT_WIDTH-1:0]   remaining_q;
    logic [DRAIN_W-1:0]           drain_q;
    logic [WUF_ADDR_WIDTH-1:0]    cur_addr_q;
    logic [WUF_ADDR_WIDTH-1:0]    cur_addr_d;
`ifdef WUF_LOOP_EN
    logic [WUF_ADDR_WIDTH-1:0]    start_addr_q;
    logic [WUF_COUNT_WIDTH-1:0]   num_words_q;
    logic [7:0]                   loops_left_q;
`endif

    // Depth need not be a power of two, so wrap explicitly.
    always_comb begin
        cur_addr_d = (cur_addr_q == C_ADDR_LAST) ? '0 : cur_addr_q + C_ADDR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q       <= S_IDLE;
            read_q        <= 1'b0;
            addr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
            remaining_q   <= '0;
            drain_q       <= '0;
            cur_addr_q    <= '0;
`ifdef WUF_LOOP_EN
            start_addr_q  <= '0;
            num_words_q   <= '0;
            loops_left_q  <= '0;
`endif
        end else begin
            read_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mcntl__wuf__start && !mcntl__wuf__abort) begin
                        if (mcntl__wuf__num_words != '0) begin
                            cur_addr_q  <= mcntl__wuf__start_addr;
                            remaining_q <= mcntl__wuf__num_words;
`ifdef WUF_LOOP_EN
                            start_addr_q <= mcntl__wuf__start_addr;
                            num_words_q  <= mcntl__wuf__num_words;
                            loops_left_q <= mcntl__wuf__loop_count;
`endif
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (mcntl__wuf__abort) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        remaining_q <= '0;
                    end else if (!wum__wuf__stall && remaining_q != '0) begin
                        read_q      <= 1'b1;
                        addr_q      <= cur_addr_q;
                        cur_addr_q  <= cur_addr_d;
                        remaining_q <= remaining_q - C_CNT_ONE;
                        if (~&fetch_count_q) begin
                            fetch_count_q <= fetch_count_q + C_CNT_ONE;
                        end
                        if (remaining_q == C_CNT_ONE) begin
`ifdef WUF_LOOP_EN
                            // Reload on the same edge so the next pass has no bubble.
                            if (loops_left_q != 8'd0) begin
                                cur_addr_q   <= start_addr_q;
                                remaining_q  <= num_words_q;
                                loops_left_q <= loops_left_q - 8'd1;
                            end else begin
                                state_q <= S_DRAIN;
                                drain_q <= C_DRAIN_LOAD;
                            end
`else
                            state_q <= S_DRAIN;
                            drain_q <= C_DRAIN_LOAD;
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    if (mcntl__wuf__abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - C_DRAIN_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wuf__mcntl__busy        = busy_q;
    assign wuf__mcntl__done        = done_q;
    assign wuf__mcntl__fetch_count = fetch_count_q;
    assign wuf__wum__addr          = addr_q;
    assign wuf__wum__read          = read_q;

endmodule

`default_nettype wire

// File: tb/tb_wu_fetch_cntl.sv
//------------------------------------------------------------------------------
// Module      : tb_wu_fetch_cntl
// Description : Randomised and directed bench for wu_fetch_cntl against a
//               transaction-level model (honours WUF_LOOP_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wu_fetch_cntl;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;
    localparam int CW    = 16;
    localparam int DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] num_words;
    logic          abort;
    logic [7:0]    loop_count;
    logic          stall;
    logic          busy;
    logic          done;
    logic [CW-1:0] fetch_count;
    logic [AW-1:0] addr;
    logic          read;

    int n_vec = 0;
    int n_err = 0;

    // Model state: a fetch is described by its base, length and how many
    // reads have gone out; done is scheduled DRAIN cycles after the last read.
    bit      m_valid  = 1'b0;
    bit      m_active = 1'b0;
    int      m_base, m_num, m_total, m_issued;
    longint  m_cyc = 0;
    longint  m_done_at = -1;
    logic          e_read, e_busy, e_done;
    logic [AW-1:0] e_addr;
    int            e_cnt;

    always #5 clk = ~clk;

    wu_fetch_cntl #(
        .WUF_ADDR_WIDTH  (AW),
        .WUF_MEM_DEPTH   (DEPTH),
        .WUF_COUNT_WIDTH (CW),
        .WUF_DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk                    (clk),
        .reset_poweron          (rst),
        .mcntl__wuf__start      (start),
        .mcntl__wuf__start_addr (start_addr),
        .mcntl__wuf__num_words  (num_words),
        .mcntl__wuf__abort      (abort),
`ifdef WUF_LOOP_EN
        .mcntl__wuf__loop_count (loop_count),
`endif
        .wuf__mcntl__busy       (busy),
        .wuf__mcntl__done       (done),
        .wuf__mcntl__fetch_count(fetch_count),
        .wuf__wum__addr         (addr),
        .wuf__wum__read         (read),
        .wum__wuf__stall        (stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic model_step();
        int lc;
`ifdef WUF_LOOP_EN
        lc = int'(loop_count);
`else
        lc = 0;
`endif
        if (rst) begin
            m_valid   = 1'b1;
            m_active  = 1'b0;
            m_done_at = -1;
            e_read = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = '0; e_cnt = 0;
        end else if (m_valid) begin
            e_read = 1'b0;
            e_done = 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    if (num_words == '0) begin
                        e_done = 1'b1;
                    end else begin
                        m_active  = 1'b1;
                        m_issued  = 0;
                        m_num     = int'(num_words);
                        m_total   = m_num * (lc + 1);
                        m_base    = int'(start_addr);
                        m_done_at = -1;
                    end
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (m_issued < m_total) begin
                if (!stall) begin
                    e_read = 1'b1;
                    e_addr = AW'((m_base + (m_issued % m_num)) % DEPTH);
                    m_issued++;
                    if (e_cnt != 65535) e_cnt++;
                    if (m_issued == m_total) m_done_at = m_cyc + 1 + DRAIN;
                end
            end else if (m_cyc + 1 == m_done_at) begin
                e_done   = 1'b1;
                m_active = 1'b0;
            end
            e_busy = m_active;
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            chk("m.read",  32'(read),        32'(e_read));
            chk("m.addr",  32'(addr),        32'(e_addr));
            chk("m.busy",  32'(busy),        32'(e_busy));
            chk("m.done",  32'(done),        32'(e_done));
            chk("m.count", 32'(fetch_count), 32'(e_cnt));
        end
    endtask

    // Inputs are stable from the previous negedge, so the model samples them here.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        m_cyc++;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input logic [AW-1:0] a, input logic [CW-1:0] n);
        start = 1'b1; start_addr = a; num_words = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; num_words = '0;
        abort = 1'b0; loop_count = 8'd0; stall = 1'b1;
        @(negedge clk);
        ticks(3);
        chk("lit.rst_read",  32'(read), 0);
        chk("lit.rst_busy",  32'(busy), 0);
        chk("lit.rst_count", 32'(fetch_count), 0);
        chk("lit.rst_addr",  32'(addr), 0);
        rst = 1'b0;
        tick();
        stall = 1'b0;
        tick();

        // Basic: 4 words from 0x010
        go(12'h010, 16'd4);                              // now T+1
        chk("lit.basic_busy", 32'(busy), 1);
        chk("lit.basic_noread", 32'(read), 0);
        tick();
        chk("lit.basic_rd0", 32'(read), 1);
        chk("lit.basic_a0",  32'(addr), 32'h010);
        ticks(3);
        chk("lit.basic_a3",  32'(addr), 32'h013);
        ticks(3);                                        // T+8
        chk("lit.basic_done", 32'(done), 1);
        chk("lit.basic_idle", 32'(busy), 0);
        chk("lit.basic_cnt",  32'(fetch_count), 4);
        ticks(2);

        // Stall high for T+2..T+3
        go(12'h010, 16'd3);
        tick();                                          // T+2
        chk("lit.stall_rd0", 32'(read), 1);
        stall = 1'b1;
        tick();
        chk("lit.stall_hold", 32'(read), 0);
        chk("lit.stall_addr", 32'(addr), 32'h010);
        tick();                                          // T+4
        stall = 1'b0;
        tick();                                          // T+5
        chk("lit.stall_a1", 32'(addr), 32'h011);
        tick();
        chk("lit.stall_a2", 32'(addr), 32'h012);
        ticks(3);                                        // T+9
        chk("lit.stall_done", 32'(done), 1);
        ticks(2);

        // Wrap at memory depth
        go(12'hFFE, 16'd4);
        tick();
        chk("lit.wrap0", 32'(addr), 32'hFFE);
        tick();
        chk("lit.wrap1", 32'(addr), 32'hFFF);
        tick();
        chk("lit.wrap2", 32'(addr), 32'h000);
        tick();
        chk("lit.wrap3", 32'(addr), 32'h001);
        ticks(5);

        // Zero words: immediate done, never busy
        go(12'h123, 16'd0);
        chk("lit.zero_done", 32'(done), 1);
        chk("lit.zero_busy", 32'(busy), 0);
        ticks(2);

        // Start with abort in IDLE does nothing
        abort = 1'b1;
        go(12'h040, 16'd5);
        abort = 1'b0;
        chk("lit.sa_busy", 32'(busy), 0);
        chk("lit.sa_done", 32'(done), 0);
        ticks(2);

        // Abort during 2nd of 8 reads, after fresh reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        go(12'h200, 16'd8);
        ticks(2);                                        // T+3: 2nd read
        chk("lit.ab_rd2", 32'(read), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("lit.ab_read", 32'(read), 0);
        chk("lit.ab_busy", 32'(busy), 0);
        chk("lit.ab_cnt",  32'(fetch_count), 2);
        ticks(6);
        chk("lit.ab_nodone", 32'(done), 0);

        // Start while busy is ignored
        go(12'h020, 16'd2);
        tick();                                          // T+2
        start = 1'b1; start_addr = 12'h300; num_words = 16'd5;
        tick();
        start = 1'b0;
        chk("lit.sb_a1", 32'(addr), 32'h021);
        ticks(3);                                        // T+6
        chk("lit.sb_done", 32'(done), 1);
        ticks(3);
        chk("lit.sb_idle", 32'(busy), 0);

        // Reset mid-fetch
        go(12'h080, 16'd6);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit.mr_read", 32'(read), 0);
        chk("lit.mr_addr", 32'(addr), 0);
        chk("lit.mr_busy", 32'(busy), 0);
        chk("lit.mr_cnt",  32'(fetch_count), 0);
        ticks(2);

`ifdef WUF_LOOP_EN
        loop_count = 8'd2;
        go(12'h100, 16'd2);
        loop_count = 8'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lit.loop_rd",   32'(read), 1);
            chk("lit.loop_addr", 32'(addr), 32'h100 + 32'(i % 2));
        end
        ticks(3);
        chk("lit.loop_done", 32'(done), 1);
        ticks(2);
`endif

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 400) == 0);
            stall = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 80) == 0);
            start = ($urandom_range(0, 5) == 0);
            start_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                     : AW'($urandom_range(DEPTH - 6, DEPTH - 1));
            num_words  = ($urandom_range(0, 9) == 0) ? '0 : CW'($urandom_range(1, 10));
            loop_count = 8'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
        ticks(40);
        chk("end.idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
